seg7_scan_capture: RTL and testbench

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

---
 rtl/seg7_scan_capture.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_capture.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Recovers BCD digits from a multiplexed active-low 7-segment scan. Each
// (segments, strobes) sample must dwell STABLE_CYCLES samples before capture.
module seg7_scan_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int NUM_DIGITS    = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    frame_valid,
   output logic                    pattern_err,
   output logic [NUM_DIGITS-1:0]   seen,
   output logic [1:0]              o_dbg_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

   localparam logic [3:0]            CNT_MAX = 4'(STABLE_CYCLES - 1);
   localparam logic [3:0]            CNT_CAP = 4'(STABLE_CYCLES - 2);
   localparam logic [NUM_DIGITS-1:0] ONE     = NUM_DIGITS'(1);

   logic [1:0]              r_rst_sync;
   logic                    w_rst_n;
   logic [6:0]              r_seg, r_seg_prev;
   logic [NUM_DIGITS-1:0]   r_an, r_an_prev;
   logic [3:0]              r_cnt;
   state_t                  r_state, w_next;
   logic [3:0]              r_slot [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   r_seen;
   logic [4*NUM_DIGITS-1:0] r_bcd;
   logic                    r_frame_valid, r_pattern_err;

   logic                    w_changed, w_any_low, w_multi, w_capture, w_illegal;
   logic [NUM_DIGITS-1:0]   w_low, w_seen_next;
   logic [3:0]              w_nib;
   logic [4*NUM_DIGITS-1:0] w_frame;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_seg      <= '1;
         r_an       <= '1;
         r_seg_prev <= '1;
         r_an_prev  <= '1;
         r_cnt      <= '0;
      end else begin
         r_seg      <= seg_n;
         r_an       <= an_n;
         r_seg_prev <= r_seg;
         r_an_prev  <= r_an;
         if (w_changed)            r_cnt <= '0;
         else if (r_cnt < CNT_MAX) r_cnt <= r_cnt + 4'd1;
      end
   end

   assign w_changed   = ({r_seg, r_an} != {r_seg_prev, r_an_prev});
   assign w_low       = ~r_an;
   assign w_any_low   = |w_low;
   assign w_multi     = ((w_low & (w_low - ONE)) != '0);
   assign w_seen_next = r_seen | w_low;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_changed) begin
         w_next = w_any_low ? SETTLE : IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_any_low) w_next = SETTLE;
            SETTLE:  if (r_cnt >= CNT_CAP) w_next = HOLD;
            HOLD:    w_next = HOLD;
            default: w_next = IDLE;
         endcase
      end
   end

   // Capture fires only on the SETTLE->HOLD edge, so a long dwell never recaptures.
   always_comb begin
      w_capture   = (r_state == SETTLE) && (w_next == HOLD);
      o_dbg_state = r_state;
   end

   always_comb begin
      w_nib     = 4'hE;
      w_illegal = 1'b0;
      case (r_seg)
         7'b1000000: w_nib = 4'h0;
         7'b1111001: w_nib = 4'h1;
         7'b0100100: w_nib = 4'h2;
         7'b0110000: w_nib = 4'h3;
         7'b0011001: w_nib = 4'h4;
         7'b0010010: w_nib = 4'h5;
         7'b0000010: w_nib = 4'h6;
         7'b1111000: w_nib = 4'h7;
         7'b0000000: w_nib = 4'h8;
         7'b0010000: w_nib = 4'h9;
         7'b1111111: w_nib = 4'hF;
         default:    w_illegal = 1'b1;
      endcase
   end

   // Frame view with the digit being captured merged in.
   always_comb begin
      w_frame = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         w_frame[4*k +: 4] = w_low[k] ? w_nib : r_slot[k];
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int k = 0; k < NUM_DIGITS; k++) r_slot[k] <= 4'hF;
         r_seen        <= '0;
         r_bcd         <= '1;
         r_frame_valid <= 1'b0;
         r_pattern_err <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         r_pattern_err <= 1'b0;
         if (w_capture) begin
            if (w_multi) begin
               r_pattern_err <= 1'b1;
            end else begin
               r_pattern_err <= w_illegal;
               for (int k = 0; k < NUM_DIGITS; k++)
                  if (w_low[k]) r_slot[k] <= w_nib;
               if (&w_seen_next) begin
                  r_bcd         <= w_frame;
                  r_frame_valid <= 1'b1;
                  r_seen        <= '0;
               end else begin
                  r_seen <= w_seen_next;
               end
            end
         end
      end
   end

   assign bcd_out     = r_bcd;
   assign frame_valid = r_frame_valid;
   assign pattern_err = r_pattern_err;
   assign seen        = r_seen;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: dwell-level reference model predicts every
// capture (cycle, frame value, error pulse) when each input segment is driven.
module tb_seg7_scan_capture;
   localparam int S = 4;
   localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
      7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
      7'b0010000};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_n = 7'h7F;
   logic [3:0]  an_n  = 4'hF;
   logic [15:0] bcd_out;
   logic        frame_valid, pattern_err;
   logic [3:0]  seen;
   logic [1:0]  dbg_state;

   seg7_scan_capture #(.STABLE_CYCLES(S), .NUM_DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
      .bcd_out(bcd_out), .frame_valid(frame_valid), .pattern_err(pattern_err),
      .seen(seen), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_bad    = 0;
   int obs_frames = 0;
   int obs_errs   = 0;

   // reference model state
   logic [3:0]  m_slot [4];
   logic [3:0]  m_seen;
   logic [15:0] m_bcd;
   logic [6:0]  last_seg;
   logic [3:0]  last_an;
   logic [15:0] exp_q[$];
   int          exp_fcyc_q[$];
   int          exp_ecyc_q[$];

   function automatic logic [4:0] ref_decode(input logic [6:0] p);
      logic [4:0] r;
      r = {1'b1, 4'hE};
      if (p == 7'h7F) r = {1'b0, 4'hF};
      for (int d = 0; d < 10; d++)
         if (SEG_TAB[d] == p) r = {1'b0, 4'(d)};
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_slot[k] = 4'hF;
      m_seen   = 4'h0;
      m_bcd    = 16'hFFFF;
      last_seg = 7'h7F;
      last_an  = 4'hF;
   endtask

   // Drive one dwell; a dwell of at least S clocks that differs from the
   // previous one and has a strobe low is captured S+1 edges after it starts.
   task automatic drive_seg(input logic [6:0] s, input logic [3:0] a, input int len);
      int ecyc;
      logic [3:0] lows;
      logic [4:0] dec;
      seg_n = s;
      an_n  = a;
      if ({s, a} != {last_seg, last_an} && a != 4'hF && len >= S) begin
         ecyc = cyc + S + 1;
         lows = ~a;
         if ($countones(lows) >= 2) begin
            exp_ecyc_q.push_back(ecyc);
         end else begin
            dec = ref_decode(s);
            if (dec[4]) exp_ecyc_q.push_back(ecyc);
            for (int k = 0; k < 4; k++) if (lows[k]) m_slot[k] = dec[3:0];
            if ((m_seen | lows) == 4'hF) begin
               m_bcd = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
               exp_q.push_back(m_bcd);
               exp_fcyc_q.push_back(ecyc);
               m_seen = 4'h0;
            end else begin
               m_seen = m_seen | lows;
            end
         end
      end
      last_seg = s;
      last_an  = a;
      repeat (len) @(negedge clk);
   endtask

   task automatic drive_idle();
      drive_seg(7'h7F, 4'hF, S + 3);
   endtask

   task automatic do_reset(input int n);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      mon_en = 1'b1;
   endtask

   // scoreboard: every observed pulse must match the head of the expected queue
   bit          mon_en = 1'b0;
   logic [15:0] prev_bcd = 16'hFFFF;
   always @(negedge clk) begin
      if (mon_en) begin
         if (frame_valid === 1'b1) begin
            obs_frames++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL frame_unexpected cyc=%0d bcd=%h", cyc, bcd_out);
            end else begin
               if (bcd_out !== exp_q[0] || cyc != exp_fcyc_q[0]) begin
                  n_bad++;
                  $display("FAIL frame_value got bcd=%h cyc=%0d want bcd=%h cyc=%0d",
                           bcd_out, cyc, exp_q[0], exp_fcyc_q[0]);
               end
               void'(exp_q.pop_front());
               void'(exp_fcyc_q.pop_front());
            end
         end
         if (pattern_err === 1'b1) begin
            obs_errs++;
            n_checks++;
            if (exp_ecyc_q.size() == 0) begin
               n_bad++;
               $display("FAIL err_unexpected cyc=%0d", cyc);
            end else begin
               if (cyc != exp_ecyc_q[0]) begin
                  n_bad++;
                  $display("FAIL err_cycle got=%0d want=%0d", cyc, exp_ecyc_q[0]);
               end
               void'(exp_ecyc_q.pop_front());
            end
         end
         if (bcd_out !== prev_bcd) begin
            n_checks++;
            if (frame_valid !== 1'b1) begin
               n_bad++;
               $display("FAIL bcd_change_without_frame got=%h prev=%h", bcd_out, prev_bcd);
            end
         end
      end
      prev_bcd = bcd_out;
   end

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (bcd_out !== 16'hFFFF || frame_valid !== 1'b0 || pattern_err !== 1'b0 ||
          seen !== 4'b0000 || dbg_state !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_values got bcd=%h fv=%b err=%b seen=%b st=%0d want FFFF 0 0 0000 0",
                  bcd_out, frame_valid, pattern_err, seen, dbg_state);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      mon_en = 1'b1;
   endtask

   task automatic test_scan_basic();
      int f0, e0;
      f0 = obs_frames; e0 = obs_errs;
      drive_seg(7'b1111001, 4'b1110, 6);
      drive_seg(7'b0100100, 4'b1101, 6);
      drive_seg(7'b0110000, 4'b1011, 6);
      drive_seg(7'b0011001, 4'b0111, 6);
      drive_idle();
      n_checks++;
      if (bcd_out !== 16'h4321 || obs_frames - f0 != 1 || obs_errs - e0 != 0 ||
          exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scan_basic got bcd=%h frames=%0d errs=%0d want bcd=4321 frames=1 errs=0",
                  bcd_out, obs_frames - f0, obs_errs - e0);
      end
   endtask

   task automatic test_dwell_boundary();
      drive_seg(7'b0100100, 4'b1011, 3);
      drive_idle();
      n_checks++;
      if (seen[2] !== 1'b0 || seen !== m_seen) begin
         n_bad++;
         $display("FAIL short_dwell got seen=%b want=%b", seen, m_seen);
      end
      drive_seg(7'b0100100, 4'b1011, S);
      drive_idle();
      n_checks++;
      if (seen !== 4'b0100 || seen !== m_seen) begin
         n_bad++;
         $display("FAIL exact_dwell got seen=%b want=0100", seen);
      end
   endtask

   task automatic test_illegal_pattern();
      int e0;
      e0 = obs_errs;
      drive_seg(7'b1010101, 4'b1101, 5);
      drive_idle();
      n_checks++;
      if (obs_errs - e0 != 1 || seen !== 4'b0110) begin
         n_bad++;
         $display("FAIL illegal_pattern got errs=%0d seen=%b want errs=1 seen=0110",
                  obs_errs - e0, seen);
      end
      drive_seg(7'b1000000, 4'b1110, 5);
      drive_seg(7'b1000000, 4'b0111, 5);
      drive_idle();
      n_checks++;
      if (bcd_out !== 16'h02E0 || bcd_out !== m_bcd) begin
         n_bad++;
         $display("FAIL illegal_slot got bcd=%h want=02e0", bcd_out);
      end
   endtask

   task automatic test_multi_strobe();
      int e0;
      drive_seg(7'b0110000, 4'b1110, 5);
      e0 = obs_errs;
      drive_seg(7'b0110000, 4'b0011, 5);
      drive_idle();
      n_checks++;
      if (obs_errs - e0 != 1 || seen !== 4'b0001 || exp_ecyc_q.size() != 0) begin
         n_bad++;
         $display("FAIL multi_strobe got errs=%0d seen=%b want errs=1 seen=0001",
                  obs_errs - e0, seen);
      end
   endtask

   task automatic test_overwrite();
      drive_seg(7'b0010010, 4'b1110, 5);
      drive_idle();
      n_checks++;
      if (seen !== 4'b0001) begin
         n_bad++;
         $display("FAIL overwrite_seen got=%b want=0001", seen);
      end
      drive_seg(7'b1111000, 4'b1110, 5);
      drive_seg(7'b1000000, 4'b1101, 5);
      drive_seg(7'b1000000, 4'b1011, 5);
      drive_seg(7'b1000000, 4'b0111, 5);
      drive_idle();
      n_checks++;
      if (bcd_out !== 16'h0007 || seen !== 4'b0000) begin
         n_bad++;
         $display("FAIL overwrite_frame got bcd=%h seen=%b want 0007 0000", bcd_out, seen);
      end
   endtask

   task automatic test_reset_mid_frame();
      drive_seg(7'b0010000, 4'b1110, 6);
      drive_seg(7'b0010000, 4'b1101, 6);
      drive_seg(7'b0010000, 4'b1011, 6);
      drive_idle();
      n_checks++;
      if (seen !== 4'b0111) begin
         n_bad++;
         $display("FAIL pre_reset_seen got=%b want=0111", seen);
      end
      do_reset(1);
      n_checks++;
      if (bcd_out !== 16'hFFFF || seen !== 4'b0000) begin
         n_bad++;
         $display("FAIL post_reset got bcd=%h seen=%b want FFFF 0000", bcd_out, seen);
      end
      drive_seg(7'b0010000, 4'b1110, 6);
      drive_seg(7'b0010000, 4'b1101, 6);
      drive_seg(7'b0010000, 4'b1011, 6);
      drive_idle();
      n_checks++;
      if (bcd_out !== 16'hFFFF || seen !== 4'b0111) begin
         n_bad++;
         $display("FAIL partial_after_reset got bcd=%h seen=%b want FFFF 0111", bcd_out, seen);
      end
      drive_seg(7'b0010000, 4'b0111, 6);
      drive_idle();
      n_checks++;
      if (bcd_out !== 16'h9999) begin
         n_bad++;
         $display("FAIL frame_after_reset got=%h want=9999", bcd_out);
      end
   endtask

   task automatic test_random();
      logic [6:0] s;
      logic [3:0] a;
      int r, k, len;
      for (int i = 0; i < 80; i++) begin
         do begin
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 3);
            a = 4'(~(4'b0001 << k));
            if (r < 2) begin
               a = 4'hF;
               s = 7'($urandom);
            end else if (r == 2) begin
               s = SEG_TAB[$urandom_range(0, 9)];
               do a = 4'($urandom); while ($countones(~a) < 2);
            end else if (r == 3) begin
               do s = 7'($urandom); while (ref_decode(s) != {1'b1, 4'hE});
            end else if (r == 4) begin
               s = 7'h7F;
            end else begin
               s = SEG_TAB[$urandom_range(0, 9)];
            end
         end while ({s, a} == {last_seg, last_an});
         len = $urandom_range(1, S + 3);
         drive_seg(s, a, len);
      end
      drive_idle();
      n_checks++;
      if (bcd_out !== m_bcd || seen !== m_seen ||
          exp_q.size() != 0 || exp_ecyc_q.size() != 0) begin
         n_bad++;
         $display("FAIL random_end got bcd=%h seen=%b pend=%0d/%0d want bcd=%h seen=%b pend=0/0",
                  bcd_out, seen, exp_q.size(), exp_ecyc_q.size(), m_bcd, m_seen);
      end
   endtask

   initial begin
      test_reset();
      test_scan_basic();
      test_dwell_boundary();
      test_illegal_pattern();
      test_multi_strobe();
      test_overwrite();
      test_reset_mid_frame();
      test_random();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
